// File: rtl/instruction_encoder.sv
// rtl/instruction_encoder.sv - RV32I instruction packer with range check and 2-entry address-tagged output FIFO
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   in_valid / in_ready   encode request handshake; in_ready = fifo not full
//   in_opcode .. in_imm   instruction fields and the immediate as the decoder reproduces it
//   out_valid / out_ready FIFO head handshake
//   out_instr, out_addr   encoded word at the FIFO head and its instruction-memory address
//   err_pulse             one cycle after an accepted request that failed encoding
//   err_count             saturating count of rejected requests
module instruction_encoder #(
  parameter int                    ADDR_WIDTH    = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR     = '0,
  parameter int                    ERR_CNT_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [6:0]               in_opcode,
  input  logic [4:0]               in_rd,
  input  logic [4:0]               in_rs1,
  input  logic [4:0]               in_rs2,
  input  logic [2:0]               in_funct3,
  input  logic [6:0]               in_funct7,
  input  logic [31:0]              in_imm,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_instr,
  output logic [ADDR_WIDTH-1:0]    out_addr,
  output logic                     err_pulse,
  output logic [ERR_CNT_WIDTH-1:0] err_count
);

  typedef enum logic [2:0] {
    FMT_U,
    FMT_J,
    FMT_I,
    FMT_B,
    FMT_S,
    FMT_R,
    FMT_BAD
  } fmt_t;

  fmt_t        fmt;
  logic [31:0] enc_instr;
  logic        enc_ok;

  logic [31:0]           mem_instr [2];
  logic [ADDR_WIDTH-1:0] mem_addr  [2];
  logic                  rd_ptr;
  logic                  wr_ptr;
  logic [1:0]            count;
  logic [ADDR_WIDTH-1:0] addr_cnt;

  logic accept;
  logic push;
  logic pop;

  // Immediate fits a sign-extended field when all bits from the field's
  // sign bit upward agree.
  logic sext12_ok;
  logic sext13_ok;
  logic sext21_ok;

  assign sext12_ok = (&in_imm[31:11]) | ~(|in_imm[31:11]);
  assign sext13_ok = (&in_imm[31:12]) | ~(|in_imm[31:12]);
  assign sext21_ok = (&in_imm[31:20]) | ~(|in_imm[31:20]);

  always_comb begin
    fmt = FMT_BAD;
    case (in_opcode)
      7'b0110111, 7'b0010111:                                     fmt = FMT_U;
      7'b1101111:                                                 fmt = FMT_J;
      7'b1100111, 7'b0000011, 7'b0010011, 7'b0001111, 7'b1110011: fmt = FMT_I;
      7'b1100011:                                                 fmt = FMT_B;
      7'b0100011:                                                 fmt = FMT_S;
      7'b0110011:                                                 fmt = FMT_R;
      default:                                                    fmt = FMT_BAD;
    endcase
  end

  always_comb begin
    enc_instr = '0;
    enc_ok    = 1'b0;
    case (fmt)
      FMT_U: begin
        enc_instr = {in_imm[31:12], in_rd, in_opcode};
        enc_ok    = (in_imm[11:0] == 12'd0);
      end
      FMT_J: begin
        enc_instr = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
        enc_ok    = sext21_ok & ~in_imm[0];
      end
      FMT_I: begin
        enc_instr = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
        enc_ok    = sext12_ok;
      end
      FMT_B: begin
        enc_instr = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                     in_imm[4:1], in_imm[11], in_opcode};
        enc_ok    = sext13_ok & ~in_imm[0];
      end
      FMT_S: begin
        enc_instr = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
        enc_ok    = sext12_ok;
      end
      FMT_R: begin
        enc_instr = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
        enc_ok    = 1'b1;
      end
      default: begin
        enc_instr = '0;
        enc_ok    = 1'b0;
      end
    endcase
  end

  // in_ready comes from the registered count only, so no combinational
  // path exists from out_ready or in_valid to in_ready.
  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign out_instr = mem_instr[rd_ptr];
  assign out_addr  = mem_addr[rd_ptr];

  assign accept = in_valid & in_ready;
  assign push   = accept & enc_ok;
  assign pop    = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        mem_instr[i] <= '0;
        mem_addr[i]  <= BASE_ADDR;
      end
      rd_ptr    <= 1'b0;
      wr_ptr    <= 1'b0;
      count     <= 2'd0;
      addr_cnt  <= BASE_ADDR;
      err_pulse <= 1'b0;
      err_count <= '0;
    end else begin
      if (push) begin
        mem_instr[wr_ptr] <= enc_instr;
        mem_addr[wr_ptr]  <= addr_cnt;
        wr_ptr            <= ~wr_ptr;
        addr_cnt          <= addr_cnt + ADDR_WIDTH'(4);
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
      err_pulse <= accept & ~enc_ok;
      if (accept && !enc_ok && !(&err_count)) begin
        err_count <= err_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_instruction_encoder.sv
// tb/tb_instruction_encoder.sv - self-checking bench for instruction_encoder
module tb_instruction_encoder;

  localparam int          AW   = 32;
  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam int          ECW  = 2;

  logic           clk = 1'b0;
  logic           reset;
  logic           in_valid;
  logic           in_ready;
  logic [6:0]     in_opcode;
  logic [4:0]     in_rd;
  logic [4:0]     in_rs1;
  logic [4:0]     in_rs2;
  logic [2:0]     in_funct3;
  logic [6:0]     in_funct7;
  logic [31:0]    in_imm;
  logic           out_valid;
  logic           out_ready;
  logic [31:0]    out_instr;
  logic [AW-1:0]  out_addr;
  logic           err_pulse;
  logic [ECW-1:0] err_count;

  instruction_encoder #(
    .ADDR_WIDTH   (AW),
    .BASE_ADDR    (BASE),
    .ERR_CNT_WIDTH(ECW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_opcode(in_opcode),
    .in_rd    (in_rd),
    .in_rs1   (in_rs1),
    .in_rs2   (in_rs2),
    .in_funct3(in_funct3),
    .in_funct7(in_funct7),
    .in_imm   (in_imm),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_instr(out_instr),
    .out_addr (out_addr),
    .err_pulse(err_pulse),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] addr;
  } entry_t;

  entry_t      q[$];
  logic [31:0] m_addr;
  int          m_cnt;
  bit          m_pulse;
  bit          m_rst;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference encoder: format from the opcode, range from signed arithmetic,
  // bit placement by shifting each immediate slice into its slot.
  function automatic void ref_encode(input logic [6:0] op, input logic [4:0] rd,
                                     input logic [4:0] rs1, input logic [4:0] rs2,
                                     input logic [2:0] f3, input logic [6:0] f7,
                                     input logic [31:0] imm,
                                     output logic [31:0] w, output bit ok);
    int          si;
    logic [31:0] o, d, s1, s2, fn3, fn7;
    si  = $signed(imm);
    o   = 32'(op);
    d   = 32'(rd) << 7;
    s1  = 32'(rs1) << 15;
    s2  = 32'(rs2) << 20;
    fn3 = 32'(f3) << 12;
    fn7 = 32'(f7) << 25;
    w   = 32'd0;
    ok  = 1'b0;
    case (op)
      7'h37, 7'h17: begin
        w  = (imm & 32'hFFFF_F000) | d | o;
        ok = ((imm & 32'hFFF) == 0);
      end
      7'h6F: begin
        w  = (((imm >> 20) & 1) << 31) | (((imm >> 1) & 32'h3FF) << 21) |
             (((imm >> 11) & 1) << 20) | (((imm >> 12) & 32'hFF) << 12) | d | o;
        ok = (si >= -1048576) && (si <= 1048575) && (si % 2 == 0);
      end
      7'h67, 7'h03, 7'h13, 7'h0F, 7'h73: begin
        w  = ((imm & 32'hFFF) << 20) | s1 | fn3 | d | o;
        ok = (si >= -2048) && (si <= 2047);
      end
      7'h63: begin
        w  = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 32'h3F) << 25) | s2 | s1 | fn3 |
             (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 1) << 7) | o;
        ok = (si >= -4096) && (si <= 4095) && (si % 2 == 0);
      end
      7'h23: begin
        w  = (((imm >> 5) & 32'h7F) << 25) | s2 | s1 | fn3 | ((imm & 32'h1F) << 7) | o;
        ok = (si >= -2048) && (si <= 2047);
      end
      7'h33: begin
        w  = fn7 | s2 | s1 | fn3 | d | o;
        ok = 1'b1;
      end
      default: ok = 1'b0;
    endcase
  endfunction

  task automatic check_outputs();
    chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
    chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
    chk("err_pulse", 32'(err_pulse), 32'(m_pulse));
    chk("err_count", 32'(err_count), 32'(m_cnt));
    if (q.size() != 0) begin
      chk("out_instr", out_instr, q[0].instr);
      chk("out_addr", out_addr, q[0].addr);
    end else if (m_rst) begin
      chk("rst_instr", out_instr, 32'd0);
      chk("rst_addr", out_addr, BASE);
    end
  endtask

  // Called at a falling edge with inputs already driven; advances one clock
  // and checks the DUT against the model at the following falling edge.
  task automatic tick();
    bit          acc, pop, ok;
    logic [31:0] w;
    acc = in_valid && (q.size() < 2) && !reset;
    pop = (q.size() != 0) && out_ready && !reset;
    ref_encode(in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm, w, ok);
    @(posedge clk);
    if (reset) begin
      q.delete();
      m_addr  = BASE;
      m_cnt   = 0;
      m_pulse = 1'b0;
      m_rst   = 1'b1;
    end else begin
      if (pop) void'(q.pop_front());
      if (acc && ok) begin
        q.push_back('{instr: w, addr: m_addr});
        m_addr = m_addr + 32'd4;
        m_rst  = 1'b0;
      end
      m_pulse = acc && !ok;
      if (acc && !ok && m_cnt < (1 << ECW) - 1) m_cnt++;
    end
    @(negedge clk);
    check_outputs();
  endtask

  task automatic set_req(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [31:0] imm);
    in_opcode = op;
    in_rd     = rd;
    in_rs1    = rs1;
    in_rs2    = rs2;
    in_funct3 = f3;
    in_funct7 = f7;
    in_imm    = imm;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  typedef struct {
    string       name;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic [31:0] exp_instr;
    bit          exp_ok;
  } vec_t;

  function automatic vec_t mk(input string n, input logic [6:0] op, input logic [4:0] rd,
                              input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [2:0] f3, input logic [6:0] f7,
                              input logic [31:0] imm, input logic [31:0] ei, input bit eo);
    vec_t v;
    v.name = n; v.op = op; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.f3 = f3; v.f7 = f7;
    v.imm = imm; v.exp_instr = ei; v.exp_ok = eo;
    return v;
  endfunction

  logic [6:0] ops [9] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13, 7'h63, 7'h23, 7'h33};
  int         bnd [10] = '{2047, 2048, -2048, -2049, 4094, -4096, 4096, 1048574, 1048576, -1048576};

  initial begin
    vec_t        vecs[$];
    logic [31:0] t_addr;
    logic [31:0] got[$];
    bit          acc_now;
    int          n;

    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    set_req(7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    q.delete();
    m_addr = BASE; m_cnt = 0; m_pulse = 1'b0; m_rst = 1'b1;
    @(negedge clk);
    tick();
    do_reset();

    // Table-driven vectors, streamed with out_ready=1 so each word is the head
    // one cycle after its accept.
    vecs.push_back(mk("addi",      7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5,         32'h0050_0093, 1));
    vecs.push_back(mk("lui",       7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, 32'h1234_52B7, 1));
    vecs.push_back(mk("jal",       7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFC, 32'hFFDF_F0EF, 1));
    vecs.push_back(mk("beq",       7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd8,         32'h0020_8463, 1));
    vecs.push_back(mk("sw",        7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8,         32'h0020_A423, 1));
    vecs.push_back(mk("add",       7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'hDEAD_BEEF, 32'h0020_81B3, 1));
    vecs.push_back(mk("sub",       7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'd0,        32'h4020_81B3, 1));
    vecs.push_back(mk("addi_min",  7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_F800, 32'h8000_0093, 1));
    vecs.push_back(mk("addi_max",  7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2047,      32'h7FF0_0093, 1));
    vecs.push_back(mk("beq_min",   7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_F000, 32'h8000_0063, 1));
    vecs.push_back(mk("e_addi",    7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048,      32'd0, 0));
    vecs.push_back(mk("e_beq",     7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3,         32'd0, 0));
    vecs.push_back(mk("e_lui",     7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_1001, 32'd0, 0));
    vecs.push_back(mk("addi_next", 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5,         32'h0050_0093, 1));
    vecs.push_back(mk("e_jal",     7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0010_0000, 32'd0, 0));
    vecs.push_back(mk("e_opcode",  7'h7F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0,         32'd0, 0));

    t_addr = BASE;
    out_ready = 1'b1;
    foreach (vecs[i]) begin
      set_req(vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].f3, vecs[i].f7, vecs[i].imm);
      in_valid = 1'b1;
      tick();
      if (vecs[i].exp_ok) begin
        chk({vecs[i].name, "_valid"}, 32'(out_valid), 32'd1);
        chk({vecs[i].name, "_instr"}, out_instr, vecs[i].exp_instr);
        chk({vecs[i].name, "_addr"}, out_addr, t_addr);
        t_addr = t_addr + 32'd4;
      end else begin
        chk({vecs[i].name, "_pulse"}, 32'(err_pulse), 32'd1);
      end
      if (vecs[i].name == "e_lui") chk("err_count_3", 32'(err_count), 32'd3);
    end
    in_valid = 1'b0;
    tick();

    // Backpressure: two words fill the FIFO, the third request is held.
    do_reset();
    out_ready = 1'b0;
    set_req(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
    in_valid = 1'b1;
    tick();
    set_req(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2);
    tick();
    chk("bp_full", 32'(in_ready), 32'd0);
    set_req(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3);
    for (int i = 0; i < 3; i++) tick();
    chk("bp_held", 32'(in_ready), 32'd0);
    chk("bp_head_addr", out_addr, BASE);
    out_ready = 1'b1;
    got.delete();
    for (int i = 0; i < 8; i++) begin
      if (out_valid) got.push_back(out_addr);
      acc_now = in_valid && in_ready;
      tick();
      if (acc_now) in_valid = 1'b0;
    end
    chk("bp_count", 32'(got.size()), 32'd3);
    for (int i = 0; i < 3; i++) begin
      if (i < got.size()) chk("bp_order", got[i], BASE + 32'(4 * i));
    end

    // Error-counter saturation.
    do_reset();
    set_req(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4096);
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    in_valid = 1'b0;
    tick();
    chk("sat_count", 32'(err_count), 32'd3);

    // Reset with two words queued, nonzero error count, and a request pending.
    do_reset();
    out_ready = 1'b0;
    set_req(7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd9);
    in_valid = 1'b1;
    tick();
    set_req(7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5000);
    tick();
    set_req(7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd10);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    in_valid = 1'b0;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_errcnt", 32'(err_count), 32'd0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("rst_first_addr", out_addr, BASE);
    tick();

    // Randomized traffic against the reference model.
    out_ready = 1'b1;
    for (int i = 0; i < 600; i++) begin
      reset     = ($urandom_range(0, 99) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_opcode = ($urandom_range(0, 9) == 0) ? 7'($urandom) : ops[$urandom_range(0, 8)];
      in_rd     = 5'($urandom);
      in_rs1    = 5'($urandom);
      in_rs2    = 5'($urandom);
      in_funct3 = 3'($urandom);
      in_funct7 = 7'($urandom);
      case ($urandom_range(0, 4))
        0: in_imm = $urandom;
        1: in_imm = 32'(int'($urandom_range(0, 8191)) - 4096);
        2: in_imm = $urandom & 32'hFFFF_F000;
        3: in_imm = 32'((int'($urandom_range(0, 4095)) - 2048) * 2);
        default: begin
          n = $urandom_range(0, 9);
          in_imm = 32'(bnd[n]);
        end
      endcase
      tick();
    end
    reset    = 1'b0;
    in_valid = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_encoder.md
Name: instruction_encoder

Overview:
- Inverse of the core's immediate/field decode path: packs opcode, register, funct and 32-bit immediate fields into RV32I instruction words.
- Checks that each immediate is representable in its format (U/J/I/B/S/R).
- Buffers encoded words in a 2-entry FIFO, each tagged with a sequential instruction-memory address.
- Used by the boot/program loader and by test harnesses to write programs into instruction memory.

Parameters:
- ADDR_WIDTH, 32, width of the generated instruction address.
- BASE_ADDR, 32'h0000_0000, address assigned to the first word after reset.
- ERR_CNT_WIDTH, 8, width of the saturating error counter.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  encode request valid.
- in_ready  output  1  request accepted when in_valid & in_ready.
- in_opcode  input  7  RV32I opcode.
- in_rd  input  5  destination register.
- in_rs1  input  5  source register 1.
- in_rs2  input  5  source register 2.
- in_funct3  input  3  funct3.
- in_funct7  input  7  funct7, used by R-type only.
- in_imm  input  32  immediate value as the decoder would reproduce it.
- out_valid  output  1  FIFO head valid.
- out_ready  input  1  consumer accepts the head when out_valid & out_ready.
- out_instr  output  32  encoded instruction at the FIFO head.
- out_addr  output  ADDR_WIDTH  address tag of the head word.
- err_pulse  output  1  one-cycle pulse when a request is rejected.
- err_count  output  ERR_CNT_WIDTH  saturating count of rejected requests.

Behaviour:
- Format by opcode:
  - U: 0110111, 0010111.
  - J: 1101111.
  - I: 1100111, 0000011, 0010011, 0001111, 1110011.
  - B: 1100011.
  - S: 0100011.
  - R: 0110011.
  - Any other opcode is an error.
- Packing, standard RV32I:
  - U: imm[31:12], rd, op.
  - J: imm[20], imm[10:1], imm[11], imm[19:12], rd, op.
  - I: imm[11:0], rs1, f3, rd, op.
  - B: imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op.
  - S: imm[11:5], rs2, rs1, f3, imm[4:0], op.
  - R: f7, rs2, rs1, f3, rd, op; in_imm is ignored.
- Range check; a failing request is an error:
  - I and S: imm[31:11] all equal.
  - B: imm[31:12] all equal and imm[0]=0.
  - J: imm[31:20] all equal and imm[0]=0.
  - U: imm[11:0]=0.
- Encoding and range checking are combinational on the request. The result is written into the FIFO on the accept edge.
- Latency: a word accepted in cycle N is visible on out_* in cycle N+1 when the FIFO was empty. Throughput is 1 word/cycle while out_ready=1.
- in_ready = (fifo_count < 2). It depends only on registered state: no combinational path from out_ready or in_valid.
- Push and pop in the same cycle: count is unchanged, order is preserved, and the new entry lands behind the head.
- Accepted request with an error:
  - Not pushed; the address counter is not advanced.
  - err_pulse=1 for the cycle after the accept.
  - err_count increments and saturates at its maximum value.
- Address counter:
  - Starts at BASE_ADDR and advances by 4 on every successful push.
  - Wraps modulo 2^ADDR_WIDTH.
  - Each FIFO entry stores its own address.
- out_instr and out_addr hold stable while out_valid=1 and out_ready=0.
- FIFO state: 0, 1 or 2 entries, tracked by a read pointer, write pointer and count. Underflow is impossible (pop requires out_valid); overflow is impossible (push requires in_ready).
- Reset, including mid-operation, takes effect in the cycle it is sampled:
  - FIFO is flushed; fifo_count=0, so out_valid=0 and in_ready=1.
  - out_instr=0, out_addr=BASE_ADDR.
  - err_pulse=0, err_count=0, address counter=BASE_ADDR.
  - A request presented with reset high is not accepted.

Test Plan:
- ADDI: op=0010011, rd=1, rs1=0, f3=0, imm=5, out_ready=1 -> next cycle out_instr=0x00500093, out_addr=0x0. Then LUI: op=0110111, rd=5, imm=0x12345000 -> 0x123452B7, out_addr=0x4.
- JAL: op=1101111, rd=1, imm=0xFFFFFFFC -> 0xFFDFF0EF. BEQ: op=1100011, rs1=1, rs2=2, f3=0, imm=8 -> 0x00208463. SW: op=0100011, rs1=1, rs2=2, f3=010, imm=8 -> 0x0020A423.
- Range errors: ADDI imm=2048, BEQ imm=3, LUI imm=0x1001 -> none pushed, three err_pulse cycles, err_count=3, next valid word gets the next unused address.
- Backpressure: out_ready=0, three back-to-back requests -> in_ready=0 after the second accept, third request held. Raise out_ready -> words emerge in order with addresses 0x0, 0x4, 0x8, one per cycle.
- Error-counter saturation: with ERR_CNT_WIDTH=2, issue 5 bad requests -> err_count stops at 3.
- Reset with 2 entries queued and the error count nonzero -> next cycle out_valid=0, in_ready=1, err_count=0; first word after reset tagged with BASE_ADDR.
